shift_chain_ctrl: RTL



---
 rtl/shift_chain_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/shift_chain_ctrl.sv
// Button-driven shift/rotate/count chain with debounced load/step and auto-step prescaler.
// Latency: raw button edge to chain update is DEBOUNCE_CYCLES+3 edges; auto tick acts on the next edge.
// Backpressure: none; every accepted load/step is applied immediately, load wins over a coincident step.

module shift_chain_btn #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip;

    // Counter tops out at DEBOUNCE_CYCLES-1: the flip happens on the edge that would reach DEBOUNCE_CYCLES.
    always_comb begin
        sync1_d = ~btn_n;
        sync2_d = sync1_q;
        flip    = 1'b0;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                flip = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        db_d    = flip ? ~db_q : db_q;
        press_d = flip & ~db_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

module shift_chain_ctrl #(
    parameter int WIDTH           = 8,
    parameter int STAGES          = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_DIV        = 50000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_load_n,
    input  logic                      btn_step_n,
    input  logic [WIDTH-1:0]          switch,
    input  logic [1:0]                mode,
    input  logic                      auto_en,
    output logic [STAGES*WIDTH-1:0]   chain,
    output logic                      shift_out,
    output logic [15:0]               step_cnt
);
    localparam int N  = STAGES * WIDTH;
    localparam int PW = $clog2(AUTO_DIV);

    logic          load_pulse, step_pulse;
    logic          tick, step_req;
    logic [PW-1:0] presc_q, presc_d;
    logic [N-1:0]  chain_q, chain_d;
    logic          shift_out_q, shift_out_d;
    logic [15:0]   step_cnt_q, step_cnt_d;

    shift_chain_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_load (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_load_n),
        .press (load_pulse)
    );

    shift_chain_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_step (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_step_n),
        .press (step_pulse)
    );

    always_comb begin
        tick = auto_en && (presc_q == PW'(AUTO_DIV - 1));
        if (!auto_en || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
        step_req = step_pulse | tick;
    end

    // Stage 0 occupies the top slice, so a load only touches the most-significant WIDTH bits.
    always_comb begin
        chain_d     = chain_q;
        shift_out_d = shift_out_q;
        step_cnt_d  = step_cnt_q;
        if (load_pulse) begin
            chain_d[N-1 -: WIDTH] = switch;
        end else if (step_req) begin
            step_cnt_d = step_cnt_q + 16'd1;
            case (mode)
                2'b00: begin
                    chain_d     = {1'b0, chain_q[N-1:1]};
                    shift_out_d = chain_q[0];
                end
                2'b01: begin
                    chain_d     = {chain_q[N-2:0], 1'b0};
                    shift_out_d = chain_q[N-1];
                end
                2'b10: begin
                    chain_d     = {chain_q[0], chain_q[N-1:1]};
                    shift_out_d = chain_q[0];
                end
                default: begin
                    chain_d     = chain_q + N'(1);
                    shift_out_d = &chain_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            chain_q     <= '0;
            shift_out_q <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            presc_q     <= presc_d;
            chain_q     <= chain_d;
            shift_out_q <= shift_out_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign chain     = chain_q;
    assign shift_out = shift_out_q;
    assign step_cnt  = step_cnt_q;
endmodule
